// File: rtl/lsu_mem_arbiter.sv
// Shares the single 16-bit memory port between RMW write-back, LSU load/store and fetch.
// One transaction in flight; RMW deny blocks ls/fetch; fetch is promoted after a run of ls grants.
module lsu_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        a_rst,
   // RMW ALU write-back
   input  logic        i_rmw_req,
   input  logic [15:0] i_rmw_addr,
   input  logic [15:0] i_rmw_data,
   input  logic        i_rmw_deny,
   output logic        o_rmw_ack,
   // scheduler load/store
   input  logic        i_ls_req,
   input  logic        i_ls_we,
   input  logic [15:0] i_ls_addr,
   input  logic [15:0] i_ls_wdata,
   output logic        o_ls_ack,
   output logic        o_ls_rdy,
   output logic [15:0] o_ls_rdata,
   // instruction fetch
   input  logic        i_fetch_req,
   input  logic [15:0] i_fetch_addr,
   output logic        o_fetch_ack,
   output logic        o_fetch_rdy,
   output logic [15:0] o_fetch_data,
   // external memory
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   input  logic        i_mem_rdy,
   input  logic [15:0] i_mem_rdata
);

   localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   typedef enum logic [1:0] {
      OWN_RMW,
      OWN_LS,
      OWN_FETCH
   } owner_t;

   state_t      r_state;
   state_t      w_state_next;
   owner_t      r_owner;
   owner_t      w_owner_next;

   logic [3:0]  r_starve_cnt;
   logic [15:0] r_mem_addr;
   logic [15:0] r_mem_wdata;
   logic        r_mem_we;
   logic [15:0] r_ls_rdata;
   logic [15:0] r_fetch_data;
   logic        r_ls_rdy;
   logic        r_fetch_rdy;

   logic        w_ls_elig;
   logic        w_fetch_elig;
   logic        w_fetch_promote;
   logic        w_grant_rmw;
   logic        w_grant_ls;
   logic        w_grant_fetch;
   logic        w_grant_any;
   logic        w_done;
   logic [15:0] w_sel_addr;
   logic [15:0] w_sel_wdata;
   logic        w_sel_we;

   // Deny only gates the non-RMW requesters; the RMW write itself must drain.
   assign w_ls_elig       = i_ls_req & ~i_rmw_deny;
   assign w_fetch_elig    = i_fetch_req & ~i_rmw_deny;
   assign w_fetch_promote = w_fetch_elig & (r_starve_cnt == LP_STARVE_LIMIT);
   assign w_done          = (r_state == ST_BUSY) & i_mem_rdy;

   // Next-state, grant decode and owner selection
   always_comb begin
      w_state_next  = r_state;
      w_owner_next  = r_owner;
      w_grant_rmw   = 1'b0;
      w_grant_ls    = 1'b0;
      w_grant_fetch = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!a_rst) begin
               if (i_rmw_req) begin
                  w_grant_rmw = 1'b1;
               end else if (w_fetch_promote) begin
                  w_grant_fetch = 1'b1;
               end else if (w_ls_elig) begin
                  w_grant_ls = 1'b1;
               end else if (w_fetch_elig) begin
                  w_grant_fetch = 1'b1;
               end
            end
            if (w_grant_rmw) begin
               w_state_next = ST_BUSY;
               w_owner_next = OWN_RMW;
            end else if (w_grant_ls) begin
               w_state_next = ST_BUSY;
               w_owner_next = OWN_LS;
            end else if (w_grant_fetch) begin
               w_state_next = ST_BUSY;
               w_owner_next = OWN_FETCH;
            end
         end
         ST_BUSY: begin
            if (i_mem_rdy) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_grant_any = w_grant_rmw | w_grant_ls | w_grant_fetch;

   // Memory command from whichever requester wins this cycle
   always_comb begin
      w_sel_addr  = i_fetch_addr;
      w_sel_wdata = 16'h0000;
      w_sel_we    = 1'b0;
      if (w_grant_rmw) begin
         w_sel_addr  = i_rmw_addr;
         w_sel_wdata = i_rmw_data;
         w_sel_we    = 1'b1;
      end else if (w_grant_ls) begin
         w_sel_addr  = i_ls_addr;
         w_sel_wdata = i_ls_wdata;
         w_sel_we    = i_ls_we;
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_RMW;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 16'h0000;
         r_mem_we    <= 1'b0;
      end else if (w_grant_any) begin
         r_mem_addr  <= w_sel_addr;
         r_mem_wdata <= w_sel_wdata;
         r_mem_we    <= w_sel_we;
      end
   end

   // Counts ls wins while fetch waits; an RMW grant with fetch pending leaves it alone.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_starve_cnt <= 4'd0;
      end else if (w_grant_any) begin
         if (w_grant_fetch || !i_fetch_req) begin
            r_starve_cnt <= 4'd0;
         end else if (w_grant_ls && (r_starve_cnt < LP_STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_ls_rdy     <= 1'b0;
         r_fetch_rdy  <= 1'b0;
         r_ls_rdata   <= 16'h0000;
         r_fetch_data <= 16'h0000;
      end else begin
         r_ls_rdy    <= w_done & (r_owner == OWN_LS);
         r_fetch_rdy <= w_done & (r_owner == OWN_FETCH);
         // Stores complete without disturbing the last load result
         if (w_done && (r_owner == OWN_LS) && !r_mem_we) begin
            r_ls_rdata <= i_mem_rdata;
         end
         if (w_done && (r_owner == OWN_FETCH)) begin
            r_fetch_data <= i_mem_rdata;
         end
      end
   end

   assign o_rmw_ack    = w_grant_rmw;
   assign o_ls_ack     = w_grant_ls;
   assign o_fetch_ack  = w_grant_fetch;
   assign o_ls_rdy     = r_ls_rdy;
   assign o_ls_rdata   = r_ls_rdata;
   assign o_fetch_rdy  = r_fetch_rdy;
   assign o_fetch_data = r_fetch_data;
   assign o_mem_req    = (r_state == ST_BUSY);
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: hand-computed expectations per cycle, checked
// with immediate assertions; the bench plays the memory by driving mem_rdy itself.
module tb_lsu_mem_arbiter;

   logic        clk = 1'b0;
   logic        a_rst;
   logic        rmw_req, rmw_deny, rmw_ack;
   logic [15:0] rmw_addr, rmw_data;
   logic        ls_req, ls_we, ls_ack, ls_rdy;
   logic [15:0] ls_addr, ls_wdata, ls_rdata;
   logic        fetch_req, fetch_ack, fetch_rdy;
   logic [15:0] fetch_addr, fetch_data;
   logic        mem_req, mem_we, mem_rdy;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .a_rst        (a_rst),
      .i_rmw_req    (rmw_req),
      .i_rmw_addr   (rmw_addr),
      .i_rmw_data   (rmw_data),
      .i_rmw_deny   (rmw_deny),
      .o_rmw_ack    (rmw_ack),
      .i_ls_req     (ls_req),
      .i_ls_we      (ls_we),
      .i_ls_addr    (ls_addr),
      .i_ls_wdata   (ls_wdata),
      .o_ls_ack     (ls_ack),
      .o_ls_rdy     (ls_rdy),
      .o_ls_rdata   (ls_rdata),
      .i_fetch_req  (fetch_req),
      .i_fetch_addr (fetch_addr),
      .o_fetch_ack  (fetch_ack),
      .o_fetch_rdy  (fetch_rdy),
      .o_fetch_data (fetch_data),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdy    (mem_rdy),
      .i_mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Serve a granted transaction for n BUSY cycles. Called in the grant cycle;
   // drop_mask (bit0 rmw, bit1 ls, bit2 fetch) withdraws the served request.
   // Returns settled in the cycle after mem_rdy (the rdy cycle).
   task automatic busy(input string tag, input logic [2:0] drop_mask, input int n,
                       input logic [15:0] rd, input logic [15:0] exp_addr,
                       input logic exp_we, input logic chk_wd, input logic [15:0] exp_wd);
      for (int k = 1; k <= n; k++) begin
         cyc();
         if (k == 1) begin
            if (drop_mask[0]) rmw_req = 1'b0;
            if (drop_mask[1]) ls_req = 1'b0;
            if (drop_mask[2]) fetch_req = 1'b0;
         end
         if (k == n) begin
            mem_rdy   = 1'b1;
            mem_rdata = rd;
         end
         #1;
         chk({tag, " mem_req"}, 16'(mem_req), 16'h1);
         chk({tag, " mem_addr"}, mem_addr, exp_addr);
         chk({tag, " mem_we"}, 16'(mem_we), 16'(exp_we));
         if (chk_wd) chk({tag, " mem_wdata"}, mem_wdata, exp_wd);
      end
      cyc();
      mem_rdy   = 1'b0;
      mem_rdata = 16'hxxxx;
      #1;
      chk({tag, " mem_req low after rdy"}, 16'(mem_req), 16'h0);
   endtask

   initial begin
      a_rst = 1'b1;
      rmw_req = 0; rmw_deny = 0; rmw_addr = 0; rmw_data = 0;
      ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
      fetch_req = 0; fetch_addr = 0;
      mem_rdy = 0; mem_rdata = 0;

      // ---- reset state ----
      cyc(); cyc();
      #1;
      chk("rst mem_req", 16'(mem_req), 16'h0);
      chk("rst mem_we", 16'(mem_we), 16'h0);
      chk("rst mem_addr", mem_addr, 16'h0);
      chk("rst mem_wdata", mem_wdata, 16'h0);
      chk("rst ls_rdata", ls_rdata, 16'h0);
      chk("rst fetch_data", fetch_data, 16'h0);
      chk("rst rdys", {14'h0, ls_rdy, fetch_rdy}, 16'h0);
      cyc();
      a_rst = 1'b0;

      // ---- single load, 3 BUSY cycles ----
      cyc();
      ls_req = 1; ls_we = 0; ls_addr = 16'h1234; ls_wdata = 16'h0000;
      #1;
      chk("load ls_ack", 16'(ls_ack), 16'h1);
      chk("load mem_req at grant", 16'(mem_req), 16'h0);
      busy("load", 3'b010, 3, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 16'h0);
      chk("load ls_rdy", 16'(ls_rdy), 16'h1);
      chk("load ls_rdata", ls_rdata, 16'hBEEF);
      chk("load no ack after", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h0);
      cyc(); #1;
      chk("load ls_rdy one cycle", 16'(ls_rdy), 16'h0);

      // ---- simultaneous rmw, ls, fetch ----
      rmw_req = 1; rmw_addr = 16'h0040; rmw_data = 16'h0007;
      ls_req = 1; ls_we = 0; ls_addr = 16'h2000;
      fetch_req = 1; fetch_addr = 16'h3000;
      #1;
      chk("all3 acks", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h4);
      busy("all3 rmw", 3'b001, 1, 16'h0000, 16'h0040, 1'b1, 1'b1, 16'h0007);
      chk("all3 rmw no rdy", {14'h0, ls_rdy, fetch_rdy}, 16'h0);
      chk("all3 second acks", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h2);
      busy("all3 ls", 3'b010, 2, 16'h1111, 16'h2000, 1'b0, 1'b0, 16'h0);
      chk("all3 ls_rdy", 16'(ls_rdy), 16'h1);
      chk("all3 ls_rdata", ls_rdata, 16'h1111);
      chk("all3 third acks", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h1);
      busy("all3 fetch", 3'b100, 1, 16'h2222, 16'h3000, 1'b0, 1'b0, 16'h0);
      chk("all3 fetch_rdy", 16'(fetch_rdy), 16'h1);
      chk("all3 fetch_data", fetch_data, 16'h2222);
      chk("all3 ls_rdy quiet", 16'(ls_rdy), 16'h0);

      // ---- deny blocks ls and fetch ----
      rmw_deny = 1;
      ls_req = 1; ls_we = 0; ls_addr = 16'h4000;
      fetch_req = 1; fetch_addr = 16'h4100;
      #1;
      chk("deny acks", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h0);
      cyc(); #1;
      chk("deny mem_req", 16'(mem_req), 16'h0);
      chk("deny acks held", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h0);
      cyc();
      rmw_deny = 0;
      #1;
      chk("deny release ls_ack", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h2);
      busy("deny ls", 3'b110, 1, 16'h3333, 16'h4000, 1'b0, 1'b0, 16'h0);
      chk("deny ls_rdata", ls_rdata, 16'h3333);

      // ---- mem_rdy in IDLE ignored, then a store ----
      cyc();
      mem_rdy = 1; mem_rdata = 16'hAAAA;
      #1;
      chk("idle rdy mem_req", 16'(mem_req), 16'h0);
      cyc();
      mem_rdy = 0;
      #1;
      chk("idle rdy no pulse", {14'h0, ls_rdy, fetch_rdy}, 16'h0);
      chk("idle rdy ls_rdata", ls_rdata, 16'h3333);
      chk("idle rdy fetch_data", fetch_data, 16'h2222);
      cyc();
      ls_req = 1; ls_we = 1; ls_addr = 16'h0100; ls_wdata = 16'h55AA;
      #1;
      chk("store ls_ack", 16'(ls_ack), 16'h1);
      busy("store", 3'b010, 2, 16'hDEAD, 16'h0100, 1'b1, 1'b1, 16'h55AA);
      chk("store ls_rdy", 16'(ls_rdy), 16'h1);
      chk("store ls_rdata kept", ls_rdata, 16'h3333);

      // ---- starvation: ls and fetch held continuously ----
      cyc();
      ls_req = 1; ls_we = 0; ls_addr = 16'h5000; ls_wdata = 16'h0000;
      fetch_req = 1; fetch_addr = 16'h6000;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("starve ls grant %0d", i), {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h2);
         busy("starve ls", 3'b000, 1, 16'h1000 + 16'(i), 16'h5000, 1'b0, 1'b0, 16'h0);
         chk($sformatf("starve ls_rdata %0d", i), ls_rdata, 16'h1000 + 16'(i));
      end
      chk("starve fetch promoted", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h1);
      busy("starve fetch", 3'b000, 1, 16'h7777, 16'h6000, 1'b0, 1'b0, 16'h0);
      chk("starve fetch_rdy", 16'(fetch_rdy), 16'h1);
      chk("starve fetch_data", fetch_data, 16'h7777);
      chk("starve ls resumes", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h2);
      busy("starve ls again", 3'b000, 1, 16'h8888, 16'h5000, 1'b0, 1'b0, 16'h0);
      chk("starve counter cleared", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h2);
      ls_req = 0; fetch_req = 0;
      #1;
      chk("starve withdraw", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h0);

      // ---- reset during BUSY ----
      cyc();
      ls_req = 1; ls_we = 0; ls_addr = 16'h7000;
      #1;
      chk("rstbusy ls_ack", 16'(ls_ack), 16'h1);
      cyc();
      ls_req = 0;
      #1;
      chk("rstbusy mem_req before", 16'(mem_req), 16'h1);
      cyc();
      a_rst = 1;
      #1;
      chk("rstbusy mem_req dropped", 16'(mem_req), 16'h0);
      chk("rstbusy ls_rdata cleared", ls_rdata, 16'h0);
      cyc();
      mem_rdy = 1; mem_rdata = 16'h4444;
      cyc();
      mem_rdy = 0;
      a_rst = 0;
      #1;
      chk("rstbusy no rdy", {14'h0, ls_rdy, fetch_rdy}, 16'h0);
      cyc(); #1;
      chk("rstbusy no rdy later", {14'h0, ls_rdy, fetch_rdy}, 16'h0);
      chk("rstbusy idle", 16'(mem_req), 16'h0);
      fetch_req = 1; fetch_addr = 16'h8000;
      #1;
      chk("rstbusy fetch_ack", {13'h0, rmw_ack, ls_ack, fetch_ack}, 16'h1);
      busy("rstbusy fetch", 3'b100, 2, 16'h9999, 16'h8000, 1'b0, 1'b0, 16'h0);
      chk("rstbusy fetch_rdy", 16'(fetch_rdy), 16'h1);
      chk("rstbusy fetch_data", fetch_data, 16'h9999);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
